// File: rtl/mem_access_stage_if.sv
// Handshake and data bundle between EX and the memory-access stage.
// The master side drives the request fields and reads back the MEM/WB fields.
interface mem_access_stage_if;
  logic        valid_i;
  logic        RegWrite_i;
  logic        MemtoReg_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [2:0]  funct3_i;
  logic [31:0] ALUResult_i;
  logic [31:0] RS2data_i;
  logic [4:0]  RDaddr_i;

  logic        stall_o;
  logic        misalign_o;
  logic        RegWrite_o;
  logic        MemtoReg_o;
  logic [31:0] ALUResult_o;
  logic [31:0] Memdata_o;
  logic [4:0]  RDaddr_o;

  modport master (
    output valid_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
           funct3_i, ALUResult_i, RS2data_i, RDaddr_i,
    input  stall_o, misalign_o, RegWrite_o, MemtoReg_o,
           ALUResult_o, Memdata_o, RDaddr_o
  );

  modport slave (
    input  valid_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
           funct3_i, ALUResult_i, RS2data_i, RDaddr_i,
    output stall_o, misalign_o, RegWrite_o, MemtoReg_o,
           ALUResult_o, Memdata_o, RDaddr_o
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline memory-access stage with a fixed-latency data memory and a IDLE/BUSY stall FSM.
// Define MEM_BYTE_ACCESS_EN to enable byte/halfword loads and stores; otherwise every access is a word.
module mem_access_stage #(
  parameter int MEM_WORDS = 256,
  parameter int MEM_LAT   = 2
) (
  input logic               clk_i,
  input logic               rst_n_i,
  mem_access_stage_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic        rw;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  req_t           req;
  logic           accept, done;

  logic [31:0]    mem [MEM_WORDS];
  logic [AW-1:0]  idx;
  logic [1:0]     lane;
  logic [31:0]    rd_word;
  logic           mis;
  logic [3:0]     be;
  logic [31:0]    wd;
  logic [31:0]    ld_data;

  // FSM: next state and one-cycle strobes
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: if (bus.valid_i) begin
        accept = 1'b1;
        if (bus.MemRead_i || bus.MemWrite_i) state_nx = BUSY;
      end
      BUSY: if (cnt == '0) begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nx;
  end

  assign bus.stall_o = (state == BUSY);

  assign idx     = req.addr[AW+1:2];
  assign lane    = req.addr[1:0];
  assign rd_word = mem[idx];

`ifdef MEM_BYTE_ACCESS_EN
  logic       sz_b, sz_h;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic       unused_bits;

  // Unknown load codes fall back to word, unknown store codes fall back to word.
  always_comb begin
    sz_b = req.wr ? (req.f3 == 3'b000) : (req.f3 == 3'b000 || req.f3 == 3'b100);
    sz_h = req.wr ? (req.f3 == 3'b001) : (req.f3 == 3'b001 || req.f3 == 3'b101);
    mis  = sz_h ? lane[0] : (sz_b ? 1'b0 : (lane != 2'b00));
    ld_b = rd_word[{lane, 3'b000} +: 8];
    ld_h = lane[1] ? rd_word[31:16] : rd_word[15:0];
    if (sz_b) begin
      be      = 4'b0001 << lane;
      wd      = {4{req.wdata[7:0]}};
      ld_data = req.f3[2] ? {24'h0, ld_b} : {{24{ld_b[7]}}, ld_b};
    end else if (sz_h) begin
      be      = lane[1] ? 4'b1100 : 4'b0011;
      wd      = {2{req.wdata[15:0]}};
      ld_data = req.f3[2] ? {16'h0, ld_h} : {{16{ld_h[15]}}, ld_h};
    end else begin
      be      = 4'b1111;
      wd      = req.wdata;
      ld_data = rd_word;
    end
  end

  assign unused_bits = ^{req.addr[31:AW+2], req.rd};
`else
  logic unused_bits;

  assign mis     = (lane != 2'b00);
  assign be      = 4'b1111;
  assign wd      = req.wdata;
  assign ld_data = rd_word;

  assign unused_bits = ^{req.addr[31:AW+2], req.f3, req.rd};
`endif

  // Output register and request capture
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt             <= '0;
      req             <= '0;
      bus.misalign_o  <= 1'b0;
      bus.RegWrite_o  <= 1'b0;
      bus.MemtoReg_o  <= 1'b0;
      bus.ALUResult_o <= '0;
      bus.Memdata_o   <= '0;
      bus.RDaddr_o    <= '0;
    end else begin
      bus.misalign_o <= 1'b0;
      if (accept) begin
        req             <= '{rw: bus.RegWrite_i, rd: bus.MemRead_i, wr: bus.MemWrite_i,
                             f3: bus.funct3_i, addr: bus.ALUResult_i, wdata: bus.RS2data_i};
        bus.ALUResult_o <= bus.ALUResult_i;
        bus.RDaddr_o    <= bus.RDaddr_i;
        bus.MemtoReg_o  <= bus.MemtoReg_i;
        if (bus.MemRead_i || bus.MemWrite_i) begin
          bus.RegWrite_o <= 1'b0;
          cnt            <= CW'(MEM_LAT - 1);
        end else begin
          bus.RegWrite_o <= bus.RegWrite_i;
          bus.Memdata_o  <= '0;
        end
      end else if (state == IDLE) begin
        bus.RegWrite_o <= 1'b0;
      end else if (done) begin
        // A store (including read+write) never returns data
        bus.RegWrite_o <= req.rw & ~mis;
        bus.Memdata_o  <= (req.wr || mis) ? 32'h0 : ld_data;
        bus.misalign_o <= mis;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Memory array is not reset; writes are dropped if reset lands on the completion edge.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && done && req.wr && !mis) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][b*8 +: 8] <= wd[b*8 +: 8];
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage (MEM_LAT=2, MEM_WORDS=256).
// Expectations branch on MEM_BYTE_ACCESS_EN to match the word-only default build.
module tb_mem_access_stage;
  localparam int LAT   = 2;
  localparam int WORDS = 256;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  mem_access_stage_if bus();

  mem_access_stage #(.MEM_WORDS(WORDS), .MEM_LAT(LAT)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, rw, m2r;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic [31:0] exp_data;
    logic        exp_rw, exp_mis;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic rd, logic wr, logic rw, logic m2r, logic [2:0] f3,
                               logic [31:0] addr, logic [31:0] wdata,
                               logic [31:0] exp_data, logic exp_rw, logic exp_mis);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rw = rw; v.m2r = m2r; v.f3 = f3;
    v.addr = addr; v.wdata = wdata;
    v.exp_data = exp_data; v.exp_rw = exp_rw; v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic [4:0] rdaddr);
    bus.valid_i     = 1'b1;
    bus.MemRead_i   = v.rd;
    bus.MemWrite_i  = v.wr;
    bus.RegWrite_i  = v.rw;
    bus.MemtoReg_i  = v.m2r;
    bus.funct3_i    = v.f3;
    bus.ALUResult_i = v.addr;
    bus.RS2data_i   = v.wdata;
    bus.RDaddr_i    = rdaddr;
  endtask

  task automatic do_op(input vec_t v, input logic [4:0] rdaddr, input string tag);
    int  n;
    logic memop;
    memop = v.rd | v.wr;
    @(negedge clk);
    drive(v, rdaddr);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    if (memop) begin
      chk({tag, ".bubble_rw"}, {31'h0, bus.RegWrite_o}, 32'h0);
      chk({tag, ".stall_on"}, {31'h0, bus.stall_o}, 32'h1);
    end
    n = 0;
    while (bus.stall_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".stall_cycles"}, n, memop ? LAT : 0);
    chk({tag, ".memdata"}, bus.Memdata_o, v.exp_data);
    chk({tag, ".regwrite"}, {31'h0, bus.RegWrite_o}, {31'h0, v.exp_rw});
    chk({tag, ".misalign"}, {31'h0, bus.misalign_o}, {31'h0, v.exp_mis});
    chk({tag, ".alu"}, bus.ALUResult_o, v.addr);
    chk({tag, ".rdaddr"}, {27'h0, bus.RDaddr_o}, {27'h0, rdaddr});
    chk({tag, ".memtoreg"}, {31'h0, bus.MemtoReg_o}, {31'h0, v.m2r});
    @(posedge clk); #1;
    chk({tag, ".mis_end"}, {31'h0, bus.misalign_o}, 32'h0);
    chk({tag, ".idle_rw"}, {31'h0, bus.RegWrite_o}, 32'h0);
    chk({tag, ".alu_hold"}, bus.ALUResult_o, v.addr);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".stall"}, {31'h0, bus.stall_o}, 32'h0);
    chk({tag, ".misalign"}, {31'h0, bus.misalign_o}, 32'h0);
    chk({tag, ".regwrite"}, {31'h0, bus.RegWrite_o}, 32'h0);
    chk({tag, ".memtoreg"}, {31'h0, bus.MemtoReg_o}, 32'h0);
    chk({tag, ".alu"}, bus.ALUResult_o, 32'h0);
    chk({tag, ".memdata"}, bus.Memdata_o, 32'h0);
    chk({tag, ".rdaddr"}, {27'h0, bus.RDaddr_o}, 32'h0);
  endtask

  initial begin
    vec_t v;

    tbl.push_back(mkv(0,1,0,0,3'b010,32'h10,32'hDEADBEEF, 32'h0,       0,0));
    tbl.push_back(mkv(1,0,1,1,3'b010,32'h10,32'h0,        32'hDEADBEEF,1,0));
    tbl.push_back(mkv(0,0,1,0,3'b000,32'h1234,32'h0,      32'h0,       1,0));
`ifdef MEM_BYTE_ACCESS_EN
    tbl.push_back(mkv(0,1,0,0,3'b000,32'h13,32'h00000080, 32'h0,       0,0));
    tbl.push_back(mkv(1,0,1,1,3'b000,32'h13,32'h0,        32'hFFFFFF80,1,0));
    tbl.push_back(mkv(1,0,1,1,3'b100,32'h13,32'h0,        32'h00000080,1,0));
    tbl.push_back(mkv(1,0,1,1,3'b010,32'h10,32'h0,        32'h80ADBEEF,1,0));
`else
    tbl.push_back(mkv(0,1,0,0,3'b000,32'h13,32'h00000080, 32'h0,       0,1));
    tbl.push_back(mkv(1,0,1,1,3'b000,32'h13,32'h0,        32'h0,       0,1));
    tbl.push_back(mkv(1,0,1,1,3'b100,32'h13,32'h0,        32'h0,       0,1));
    tbl.push_back(mkv(1,0,1,1,3'b010,32'h10,32'h0,        32'hDEADBEEF,1,0));
`endif
    tbl.push_back(mkv(0,1,0,0,3'b010,32'h20,32'h11223344, 32'h0,       0,0));
    tbl.push_back(mkv(1,0,1,1,3'b001,32'h21,32'h0,        32'h0,       0,1));
    tbl.push_back(mkv(1,0,1,1,3'b010,32'h20,32'h0,        32'h11223344,1,0));
    tbl.push_back(mkv(0,1,0,0,3'b010,32'h30,32'h0,        32'h0,       0,0));
`ifdef MEM_BYTE_ACCESS_EN
    tbl.push_back(mkv(1,0,1,1,3'b101,32'h22,32'h0,        32'h00001122,1,0));
    tbl.push_back(mkv(0,1,0,0,3'b001,32'h32,32'hFFFF8001, 32'h0,       0,0));
    tbl.push_back(mkv(1,0,1,1,3'b010,32'h30,32'h0,        32'h80010000,1,0));
    tbl.push_back(mkv(1,0,1,1,3'b001,32'h32,32'h0,        32'hFFFF8001,1,0));
`else
    tbl.push_back(mkv(1,0,1,1,3'b101,32'h22,32'h0,        32'h0,       0,1));
    tbl.push_back(mkv(0,1,0,0,3'b001,32'h32,32'hFFFF8001, 32'h0,       0,1));
    tbl.push_back(mkv(1,0,1,1,3'b010,32'h30,32'h0,        32'h0,       1,0));
    tbl.push_back(mkv(1,0,1,1,3'b001,32'h32,32'h0,        32'h0,       0,1));
`endif
    // 0x410 aliases word 0x10 in a 256-word memory
    tbl.push_back(mkv(0,1,0,0,3'b010,32'h410,32'hCAFEF00D,32'h0,       0,0));
    tbl.push_back(mkv(1,0,1,1,3'b010,32'h10,32'h0,        32'hCAFEF00D,1,0));
    tbl.push_back(mkv(1,1,1,0,3'b010,32'h40,32'h00000055, 32'h0,       1,0));
    tbl.push_back(mkv(1,0,1,1,3'b010,32'h40,32'h0,        32'h00000055,1,0));
    tbl.push_back(mkv(0,1,0,0,3'b010,32'h04,32'h01020304, 32'h0,       0,0));

    bus.valid_i = 1'b0; bus.MemRead_i = 1'b0; bus.MemWrite_i = 1'b0;
    bus.RegWrite_i = 1'b0; bus.MemtoReg_i = 1'b0; bus.funct3_i = 3'b0;
    bus.ALUResult_i = '0; bus.RS2data_i = '0; bus.RDaddr_i = '0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("reset_release");

    for (int i = 0; i < tbl.size(); i++)
      do_op(tbl[i], 5'(i + 1), $sformatf("vec%0d", i));

    // Reset one cycle into a store cancels it
    v = mkv(0,1,0,0,3'b010,32'h04,32'h99999999, 32'h0,0,0);
    @(negedge clk);
    drive(v, 5'd7);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    chk("midreset.stall_before", {31'h0, bus.stall_o}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset.stall", {31'h0, bus.stall_o}, 32'h0);
    chk("midreset.regwrite", {31'h0, bus.RegWrite_o}, 32'h0);
    chk("midreset.alu", bus.ALUResult_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(mkv(1,0,1,1,3'b010,32'h04,32'h0, 32'h01020304,1,0), 5'd8, "after_reset_lw");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter MEM_WORDS, default 256: data memory depth in 32-bit words; power of two, at least 4.
REQ-002 Parameter MEM_LAT, default 2: memory access latency in cycles; at least 1.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n_i  in  1  reset, synchronous and active-low.
REQ-005 valid_i  in  1  upstream request valid this cycle.
REQ-006 RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  control bits from EX.
REQ-007 funct3_i  in  3  access size/sign code.
REQ-008 ALUResult_i  in  32  byte address, or pass-through result.
REQ-009 RS2data_i  in  32  store data.
REQ-010 RDaddr_i  in  5  destination register.
REQ-011 stall_o  out  1  stage busy; upstream holds all inputs while high.
REQ-012 misalign_o  out  1  one-cycle pulse when an access is misaligned.
REQ-013 RegWrite_o, MemtoReg_o  out  1 each; ALUResult_o, Memdata_o  out  32 each; RDaddr_o  out  5. These drive the MEM/WB register inputs.

Function
REQ-014 FSM has two states: IDLE and BUSY; stall_o SHALL be 1 exactly when state is BUSY (Moore output).
REQ-015 In IDLE with valid_i=1, the block SHALL capture all inputs at the clock edge.
REQ-016 Non-memory op (MemRead_i=MemWrite_i=0): outputs update at that same edge (latency 1), Memdata_o=0, state stays IDLE.
REQ-017 Memory op: at the accept edge, RegWrite_o=0 (bubble); ALUResult_o, RDaddr_o and MemtoReg_o take the captured values; state goes to BUSY; counter loads MEM_LAT-1.
REQ-018 In BUSY, the counter decrements each cycle; at the edge where the counter is 0, the access executes, RegWrite_o is restored, and state returns to IDLE.
REQ-019 stall_o is high for exactly MEM_LAT cycles per memory op; the result is visible MEM_LAT edges after the accept edge.
REQ-020 valid_i SHALL be ignored while stall_o=1; no request is lost if upstream holds it.
REQ-021 IDLE with valid_i=0: RegWrite_o=0 at next edge; other outputs hold their values.
REQ-022 Word index = ALUResult[log2(MEM_WORDS)+1:2]; upper address bits are ignored, so addresses wrap.
REQ-023 Loads by funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Byte/half lanes are selected by addr[1:0]. Signed codes sign-extend and unsigned codes zero-extend into Memdata_o. Other codes are treated as LW.
REQ-024 Stores by funct3: 000 SB, 001 SH, 010 SW; only the addressed byte lanes are written. Other codes are treated as SW.
REQ-025 Misaligned access (half with addr[0]=1, word with addr[1:0]!=0): no memory write, Memdata_o=0, RegWrite_o=0, misalign_o=1 for one cycle at completion; timing is unchanged.
REQ-026 MemRead_i and MemWrite_i both 1: treated as a store; Memdata_o=0.
REQ-027 A store SHALL leave Memdata_o=0; RegWrite_o follows the captured RegWrite_i.

Reset
REQ-028 While rst_n_i=0 at an edge: state=IDLE, counter=0, stall_o=0, misalign_o=0, and all data/control outputs are 0.
REQ-029 Reset asserted mid-BUSY SHALL cancel the pending access; no memory write occurs.
REQ-030 Memory array contents are not reset.

Configuration
REQ-031 Macro MEM_BYTE_ACCESS_EN defined: REQ-023/024 apply in full.
REQ-032 Macro MEM_BYTE_ACCESS_EN undefined: funct3_i is ignored, every access is a full word, and misalignment is checked on addr[1:0] only.

Verification
REQ-033 Reset with rst_n_i=0 for 2 cycles, then release -> all outputs 0, stall_o=0.
REQ-034 SW 0xDEADBEEF to 0x10, then LW 0x10 with MEM_LAT=2 -> stall_o high for 2 cycles each; Memdata_o=0xDEADBEEF; RegWrite_o=1 two edges after accept.
REQ-035 SB 0x80 to 0x13, then LB 0x13 and LBU 0x13 -> LB gives 0xFFFFFF80, LBU gives 0x00000080; bytes 0x10-0x12 unchanged.
REQ-036 LH at 0x21 -> misalign_o pulses once, RegWrite_o=0, Memdata_o=0; the word at 0x20 is unchanged.
REQ-037 Non-memory op ALUResult_i=0x1234, RDaddr_i=5 -> next edge ALUResult_o=0x1234, RDaddr_o=5, RegWrite_o=1, stall_o stays 0.
REQ-038 SW to 0x04 with rst_n_i dropped 1 cycle after accept, then LW 0x04 -> old value returned; stall_o=0 during reset.
